dff_share_arbiter: RTL

- Round-robin controller that shares one WIDTH-bit edge-triggered D register between NREQ requesters.
- Each requester raises a request with its data. The block grants one requester at a time, loads that requester's data into the shared register, and acknowledges it.
- A programmable cooldown after every write limits how often the register can be updated.
- Sits between the requesting units and the storage register; the register itself lives inside this block.

---
 rtl/dff_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin arbiter sharing one WIDTH-bit register among NREQ requesters
module dff_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int COOLDOWN = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wr_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        q,
    output logic [2:0]              last_id,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

    localparam logic [3:0]      CNT_INIT = (COOLDOWN > 0) ? 4'(COOLDOWN - 1) : 4'd0;
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    state_t            state;
    logic [2:0]        ptr;
    logic [2:0]        win_id;
    logic [3:0]        cnt;

    logic [NREQ-1:0]   elig;
    logic              pick_found;
    logic [2:0]        pick_id;
    logic [WIDTH-1:0]  sel_data;
    logic              req_hit;
    logic [2:0]        next_ptr;

    // Requesters still showing ack have already been served; they must drop req first.
    assign elig     = req & ~ack;
    assign req_hit  = |(req & gnt);
    assign next_ptr = (win_id == 3'(NREQ - 1)) ? 3'd0 : win_id + 3'd1;

    // Winner is the eligible requester at the smallest rotational distance from ptr.
    always_comb begin
        int off;
        int best_off;
        pick_found = 1'b0;
        pick_id    = 3'd0;
        best_off   = NREQ;
        off        = 0;
        for (int j = 0; j < NREQ; j++) begin
            off = (j + NREQ - int'(ptr)) % NREQ;
            if (elig[j] && off < best_off) begin
                best_off   = off;
                pick_found = 1'b1;
                pick_id    = 3'(j);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_data = wr_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q       <= '0;
            gnt     <= '0;
            ack     <= '0;
            last_id <= 3'd0;
            busy    <= 1'b0;
            ptr     <= 3'd0;
            win_id  <= 3'd0;
            cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (pick_found) begin
                        gnt    <= ONE << pick_id;
                        win_id <= pick_id;
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    if (req_hit) begin
                        q       <= sel_data;
                        ack     <= gnt;
                        last_id <= win_id;
                        ptr     <= next_ptr;
                        if (COOLDOWN > 0) begin
                            state <= COOL;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        // Requester withdrew: drop the grant without touching q or ptr.
                        ack   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                COOL: begin
                    ack <= '0;
                    gnt <= '0;
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
